// File: rtl/image_pkg.sv
// image_pkg: constants, types and helpers shared by the binary-image stages
// (edge detector, thinner, corner_finder).
//   X_W / Y_W / ADDR_W : coordinate and pixel-address widths
//   DEF_WIDTH / DEF_HEIGHT : default frame size
//   pack_addr()        : {y, x} frame-memory address packing
package image_pkg;

  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned ADDR_W     = 19;
  localparam int unsigned DEF_WIDTH  = 640;
  localparam int unsigned DEF_HEIGHT = 480;
  // Diagonal projections x+y and x-y+HEIGHT need one bit more than x.
  localparam int unsigned S_W        = 11;
  localparam int unsigned CNT_W      = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } coord_t;

  // Coordinate tag that travels alongside an outstanding memory read.
  typedef struct packed {
    logic           valid;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pix_tag_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/raster_scan_counter.sv
// raster_scan_counter: x/y raster position for a frame scan, x fastest.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : return to (0,0); has priority over advance_i
//   advance_i     : step to the next pixel in raster order
//   x_o, y_o      : current position
//   last_o        : current position is (WIDTH-1, HEIGHT-1)
module raster_scan_counter
  import image_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear_i,
  input  logic           advance_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(HEIGHT - 1);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_last_s;

  assign x_last_s = (x_q == X_MAX);
  assign last_o   = x_last_s && (y_q == Y_MAX);
  assign x_o      = x_q;
  assign y_o      = y_q;

  // Next position: clear, wrap x into the next line, step x, or hold.
  always_comb begin
    if (clear_i) begin
      x_d = {X_W{1'b0}};
      y_d = {Y_W{1'b0}};
    end else if (advance_i && x_last_s) begin
      x_d = {X_W{1'b0}};
      y_d = (y_q == Y_MAX) ? {Y_W{1'b0}} : y_q + Y_W'(1);
    end else if (advance_i) begin
      x_d = x_q + X_W'(1);
      y_d = y_q;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= {X_W{1'b0}};
      y_q <= {Y_W{1'b0}};
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/corner_finder.sv
// corner_finder: raster-scans a 1-bit image in frame memory and reports the
// four extreme set pixels (by diagonal projection) plus the set-pixel count.
//   clk, reset (async active-low), start : control
//   busy, done                           : scan in progress / one-cycle completion
//   read_addr, read_data                 : frame memory read port ({y,x}; bit 0 = pixel)
//   tl/tr/bl/br _x/_y                    : corner estimate, updated only at done
//   pixel_count, found                   : set-pixel count (saturating), any pixel set
module corner_finder
  import image_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned HEIGHT       = DEF_HEIGHT,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [35:0]       read_data,
  output logic [X_W-1:0]    tl_x,
  output logic [Y_W-1:0]    tl_y,
  output logic [X_W-1:0]    tr_x,
  output logic [Y_W-1:0]    tr_y,
  output logic [X_W-1:0]    bl_x,
  output logic [Y_W-1:0]    bl_y,
  output logic [X_W-1:0]    br_x,
  output logic [Y_W-1:0]    br_y,
  output logic [CNT_W-1:0]  pixel_count,
  output logic              found
);

  function automatic logic [S_W-1:0] diag_sum(input coord_t c);
    return S_W'(c.x) + S_W'(c.y);
  endfunction

  // Offset by HEIGHT so the anti-diagonal projection is never negative.
  function automatic logic [S_W-1:0] diag_diff(input coord_t c);
    return S_W'(c.x) - S_W'(c.y) + S_W'(HEIGHT);
  endfunction

  scan_state_e state_q, state_d;

  logic [X_W-1:0] scan_x_s;
  logic [Y_W-1:0] scan_y_s;
  logic           scan_last_s;
  logic           scan_adv_s;

  pix_tag_t [READ_LATENCY-1:0] pipe_q, pipe_d;
  pix_tag_t       head_s;
  coord_t         cur_s;
  logic [S_W-1:0] cur_sum_s, cur_diff_s;
  logic           upstream_busy_s, pipe_busy_s, drain_last_s, hit_s;

  coord_t           acc_tl_q, acc_tl_d, acc_tr_q, acc_tr_d;
  coord_t           acc_bl_q, acc_bl_d, acc_br_q, acc_br_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_inc_s;
  logic             acc_found_q, acc_found_d;

  coord_t           out_tl_q, out_tr_q, out_bl_q, out_br_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_found_q, busy_q, done_q;

  logic unused_data_s;
  assign unused_data_s = ^read_data[35:1];

  raster_scan_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_scan (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (start),
    .advance_i (scan_adv_s),
    .x_o       (scan_x_s),
    .y_o       (scan_y_s),
    .last_o    (scan_last_s)
  );

  assign read_addr = pack_addr(scan_x_s, scan_y_s);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start from any state (re)starts the scan.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_SCAN : ST_IDLE;
      ST_SCAN:  state_d = (start || !scan_last_s) ? ST_SCAN : ST_DRAIN;
      ST_DRAIN: state_d = start ? ST_SCAN : (pipe_busy_s ? ST_DRAIN : ST_IDLE);
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; drain_last_s marks the edge that retires the final read.
  always_comb begin
    scan_adv_s   = (state_q == ST_SCAN) && !scan_last_s && !start;
    drain_last_s = (state_q == ST_DRAIN) && head_s.valid && !upstream_busy_s && !start;
  end

  // Tag pipe occupancy; upstream excludes the head stage.
  always_comb begin
    upstream_busy_s = 1'b0;
    for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
      upstream_busy_s = upstream_busy_s | pipe_q[i].valid;
    end
    pipe_busy_s = upstream_busy_s | pipe_q[READ_LATENCY-1].valid;
  end

  // Tag pipe shift; the head stage lines up with read_data of the same pixel.
  always_comb begin
    pipe_d[0].valid = (state_q == ST_SCAN);
    pipe_d[0].x     = scan_x_s;
    pipe_d[0].y     = scan_y_s;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    // A restart flushes reads belonging to the abandoned scan.
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      pipe_d[i].valid = pipe_d[i].valid & ~start;
    end
  end

  // Returned pixel and its projections.
  always_comb begin
    head_s     = pipe_q[READ_LATENCY-1];
    cur_s.x    = head_s.x;
    cur_s.y    = head_s.y;
    cur_sum_s  = diag_sum(cur_s);
    cur_diff_s = diag_diff(cur_s);
    hit_s      = head_s.valid & read_data[0];
    cnt_inc_s  = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + CNT_W'(1);
  end

  // Accumulator update; strict compares keep the earliest pixel on ties.
  always_comb begin
    acc_tl_d    = acc_tl_q;
    acc_tr_d    = acc_tr_q;
    acc_bl_d    = acc_bl_q;
    acc_br_d    = acc_br_q;
    acc_cnt_d   = acc_cnt_q;
    acc_found_d = acc_found_q;
    if (start) begin
      acc_tl_d    = '{x: {X_W{1'b0}}, y: {Y_W{1'b0}}};
      acc_tr_d    = '{x: {X_W{1'b0}}, y: {Y_W{1'b0}}};
      acc_bl_d    = '{x: {X_W{1'b0}}, y: {Y_W{1'b0}}};
      acc_br_d    = '{x: {X_W{1'b0}}, y: {Y_W{1'b0}}};
      acc_cnt_d   = {CNT_W{1'b0}};
      acc_found_d = 1'b0;
    end else if (hit_s && !acc_found_q) begin
      acc_tl_d    = cur_s;
      acc_tr_d    = cur_s;
      acc_bl_d    = cur_s;
      acc_br_d    = cur_s;
      acc_cnt_d   = cnt_inc_s;
      acc_found_d = 1'b1;
    end else if (hit_s) begin
      acc_tl_d  = (cur_sum_s  < diag_sum(acc_tl_q))  ? cur_s : acc_tl_q;
      acc_br_d  = (cur_sum_s  > diag_sum(acc_br_q))  ? cur_s : acc_br_q;
      acc_tr_d  = (cur_diff_s > diag_diff(acc_tr_q)) ? cur_s : acc_tr_q;
      acc_bl_d  = (cur_diff_s < diag_diff(acc_bl_q)) ? cur_s : acc_bl_q;
      acc_cnt_d = cnt_inc_s;
    end else begin
      acc_found_d = acc_found_q;
    end
  end

  // Tag pipe and accumulator registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q      <= '0;
      acc_tl_q    <= '0;
      acc_tr_q    <= '0;
      acc_bl_q    <= '0;
      acc_br_q    <= '0;
      acc_cnt_q   <= {CNT_W{1'b0}};
      acc_found_q <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      acc_tl_q    <= acc_tl_d;
      acc_tr_q    <= acc_tr_d;
      acc_bl_q    <= acc_bl_d;
      acc_br_q    <= acc_br_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_found_q <= acc_found_d;
    end
  end

  // Result registers: loaded with the final accumulator value as done rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_tl_q    <= '0;
      out_tr_q    <= '0;
      out_bl_q    <= '0;
      out_br_q    <= '0;
      out_cnt_q   <= {CNT_W{1'b0}};
      out_found_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= drain_last_s;
      if (drain_last_s) begin
        out_tl_q    <= acc_tl_d;
        out_tr_q    <= acc_tr_d;
        out_bl_q    <= acc_bl_d;
        out_br_q    <= acc_br_d;
        out_cnt_q   <= acc_cnt_d;
        out_found_q <= acc_found_d;
      end else begin
        out_found_q <= out_found_q;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign tl_x        = out_tl_q.x;
  assign tl_y        = out_tl_q.y;
  assign tr_x        = out_tr_q.x;
  assign tr_y        = out_tr_q.y;
  assign bl_x        = out_bl_q.x;
  assign bl_y        = out_bl_q.y;
  assign br_x        = out_br_q.x;
  assign br_y        = out_br_q.y;
  assign pixel_count = out_cnt_q;
  assign found       = out_found_q;

endmodule

// File: tb/tb_corner_finder.sv
// Directed bench for corner_finder on an 8x6 image with a 2-cycle memory.
module tb_corner_finder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, found;
  logic [18:0] read_addr;
  logic [35:0] read_data;
  logic [9:0]  tl_x, tr_x, bl_x, br_x;
  logic [8:0]  tl_y, tr_y, bl_y, br_y;
  logic [18:0] pixel_count;

  int total = 0;
  int bad   = 0;

  logic        img [0:47];
  logic [18:0] addr_d1 = 19'd0;
  logic [18:0] addr_d2 = 19'd0;
  logic        px_s;

  corner_finder #(.WIDTH(8), .HEIGHT(6), .READ_LATENCY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .read_addr(read_addr), .read_data(read_data),
    .tl_x(tl_x), .tl_y(tl_y), .tr_x(tr_x), .tr_y(tr_y),
    .bl_x(bl_x), .bl_y(bl_y), .br_x(br_x), .br_y(br_y),
    .pixel_count(pixel_count), .found(found)
  );

  always #5 clk = ~clk;

  // Behavioural memory: two-cycle read latency, junk in the ignored upper bits.
  always @(posedge clk) begin
    addr_d1 <= read_addr;
    addr_d2 <= addr_d1;
  end

  always_comb begin
    px_s = 1'b0;
    if (addr_d2[18:10] < 9'd6 && addr_d2[9:0] < 10'd8)
      px_s = img[int'(addr_d2[18:10]) * 8 + int'(addr_d2[9:0])];
    read_data = {35'h2AAAAAAAA, px_s};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 48; i++) img[i] = 1'b0;
  endtask

  task automatic set_px(input int x, input int y);
    img[y * 8 + x] = 1'b1;
  endtask

  // Leaves the bench at the middle of cycle 1 after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watches 60 cycles after a start: done once in cycle 51, busy in 1..51,
  // outputs held at the previous result mid-scan, address sequencing.
  task automatic monitor(input string tag, input int prev_cnt, input int exp_cnt);
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_err = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        chk({tag, "_cnt_at_done"}, pixel_count, exp_cnt);
      end
      if (busy !== ((cyc <= 51) ? 1'b1 : 1'b0)) busy_err++;
      if (cyc == 1)  chk({tag, "_addr_c1"}, read_addr, 32'd0);
      if (cyc == 11) chk({tag, "_addr_c11"}, read_addr, 32'd1026);
      if (cyc == 30) chk({tag, "_cnt_stable"}, pixel_count, prev_cnt);
      if (cyc == 55) chk({tag, "_addr_hold"}, read_addr, 32'd5127);
      @(negedge clk);
    end
    chk({tag, "_done_count"}, done_cnt, 32'd1);
    chk({tag, "_done_cycle"}, done_cyc, 32'd51);
    chk({tag, "_busy_window"}, busy_err, 32'd0);
  endtask

  task automatic check_res(input string tag, input int tlx, input int tly,
                           input int trx, input int try_, input int blx, input int bly,
                           input int brx, input int bry, input int cnt, input int fnd);
    chk({tag, "_tl_x"}, tl_x, tlx);
    chk({tag, "_tl_y"}, tl_y, tly);
    chk({tag, "_tr_x"}, tr_x, trx);
    chk({tag, "_tr_y"}, tr_y, try_);
    chk({tag, "_bl_x"}, bl_x, blx);
    chk({tag, "_bl_y"}, bl_y, bly);
    chk({tag, "_br_x"}, br_x, brx);
    chk({tag, "_br_y"}, br_y, bry);
    chk({tag, "_count"}, pixel_count, cnt);
    chk({tag, "_found"}, found, fnd);
  endtask

  initial begin
    int early_done;
    clear_img();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_addr", read_addr, 32'd0);
    check_res("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Empty image.
    pulse_start();
    monitor("empty", 0, 0);
    check_res("empty", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Four corners of a rectangle.
    set_px(1, 1); set_px(6, 1); set_px(1, 4); set_px(6, 4);
    pulse_start();
    monitor("quad", 0, 4);
    check_res("quad", 1, 1, 6, 1, 1, 4, 6, 4, 4, 1);

    // Single pixel.
    clear_img();
    set_px(3, 2);
    pulse_start();
    monitor("single", 4, 1);
    check_res("single", 3, 2, 3, 2, 3, 2, 3, 2, 1, 1);

    // Tie on x+y: the earlier raster pixel (2,0) keeps TL and BR.
    clear_img();
    set_px(2, 0); set_px(0, 2);
    pulse_start();
    monitor("tie", 1, 2);
    check_res("tie", 2, 0, 2, 0, 0, 2, 2, 0, 2, 1);

    // Restart while busy, just after address 20 is issued.
    for (int i = 0; i < 48; i++) img[i] = 1'b1;
    pulse_start();
    early_done = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done === 1'b1) early_done++;
      @(negedge clk);
    end
    chk("restart_addr20", read_addr, 32'd2052);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    monitor("restart", 2, 48);
    chk("restart_abort_done", early_done, 32'd0);
    check_res("restart", 0, 0, 7, 0, 0, 5, 7, 5, 48, 1);

    // Asynchronous reset in the middle of a scan.
    clear_img();
    set_px(1, 1); set_px(6, 1); set_px(1, 4); set_px(6, 4);
    pulse_start();
    repeat (14) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 32'd0);
    chk("arst_addr", read_addr, 32'd0);
    check_res("arst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    early_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) early_done++;
    end
    reset = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) early_done++;
    end
    chk("arst_quiet", early_done, 32'd0);
    pulse_start();
    monitor("post_rst", 0, 4);
    check_res("post_rst", 1, 1, 6, 1, 1, 4, 6, 4, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corner_finder.md
# corner_finder

Downstream consumer of the thinned binary edge map. Raster-scans the 1-bit image in frame memory, tracks the four extreme set pixels (top-left, top-right, bottom-left, bottom-right by diagonal projection) and the set-pixel count, and presents them as the document-corner estimate for the perspective-correction stage. Runs once per `start`, read-only on memory, and signals completion with a one-cycle `done`.

## Interface
- `WIDTH`, 640: image width in pixels; x is 10 bits.
- `HEIGHT`, 480: image height in pixels; y is 9 bits.
- `READ_LATENCY`, 2: cycles from `read_addr` valid to `read_data` valid, range 1–4.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs.
- `start` in 1: single-cycle request to begin a scan.
- `busy` out 1: high from the cycle after `start` until the cycle `done` is high.
- `done` out 1: one-cycle pulse; result outputs valid from this cycle on.
- `read_addr` out 19: pixel address `{y[8:0], x[9:0]}`.
- `read_data` in 36: memory word; only bit 0 is the pixel, bits 35:1 ignored.
- `tl_x`/`tl_y`, `tr_x`/`tr_y`, `bl_x`/`bl_y`, `br_x`/`br_y` out 10/9 each: corner coordinates.
- `pixel_count` out 19: number of set pixels, saturating at 2^19−1.
- `found` out 1: at least one set pixel in the last completed scan.

## Operation
- States: IDLE → SCAN → DRAIN → IDLE. No other states.
- IDLE: `start` clears the accumulators, sets x=y=0, enters SCAN.
- SCAN: one address issued per cycle in raster order (x fastest). After `{HEIGHT−1, WIDTH−1}` is issued, enter DRAIN.
- Coordinate tags follow each address through a READ_LATENCY-deep shift register with a valid bit, so each returned pixel pairs with its own (x,y).
- For a valid returned pixel with bit 0 = 1:
  - s = x + y, 11 bits unsigned.
  - d = x − y + HEIGHT, 11 bits unsigned, never negative.
  - TL takes min s, BR takes max s, TR takes max d, BL takes min d.
  - All comparisons are strict, so the first pixel in raster order wins ties.
  - The first set pixel initialises all four corners.
  - `pixel_count` increments, saturating.
- DRAIN: lasts until the tag pipe is empty.
- On the final cycle, accumulators copy to the output registers, `done` pulses, and the block returns to IDLE.
- Outputs change only at `done`, so they stay stable during a scan.
- No set pixels: all corners 0, `pixel_count` 0, `found` 0.
- `start` while `busy`: abort and restart from x=y=0. The tag pipe is flushed, no `done` is issued for the aborted scan, and outputs keep the previous result.
- `reset` low at any time: state IDLE, all outputs 0, tag pipe cleared.

## Timing
- Reset values: `busy`, `done`, `read_addr`, all corner outputs, `pixel_count` and `found` are 0.
- Start handshake: `start` is sampled at edge E0. `read_addr` = 0 is driven in the cycle after E0 (cycle 1), and address k is driven in cycle k+1.
- Read timing: data for the address driven in cycle c is sampled at the end of cycle c+READ_LATENCY.
- Completion: `done` is high in cycle N+READ_LATENCY+1, where N = WIDTH·HEIGHT, and outputs are valid in that same cycle.
  - Default parameters: 307,203 cycles.
- `busy` is high in cycles 1 through N+READ_LATENCY+1 inclusive.
- `read_addr` holds its last value after SCAN.
- Address wrap: x wraps to 0 at WIDTH−1, and y increments at the same time.

## Structure
- Shared package `image_pkg` holds:
  - the X_W=10, Y_W=9 and ADDR_W=19 constants;
  - the default WIDTH/HEIGHT;
  - the `{y,x}` address-pack function, shared with `thinner` and the edge detector.
- One sub-module, `raster_scan_counter`: holds x/y, the wrap logic and the last-pixel flag, and is reusable by the other scan stages.
- The tag pipe and the comparators stay in the top module.

## Test plan
Benches run with WIDTH=8, HEIGHT=6, READ_LATENCY=2 and a behavioural memory model.
- Empty image, `start` → `done` in cycle 51; `found`=0, `pixel_count`=0, all corners 0; `busy` high in cycles 1–51.
- Set pixels (1,1), (6,1), (1,4), (6,4) → TL=(1,1), TR=(6,1), BL=(1,4), BR=(6,4), `pixel_count`=4, `found`=1.
- Single pixel (3,2) → all four corners=(3,2), `pixel_count`=1.
- Tie test, set pixels (2,0) and (0,2) (both s=2, first in raster order is (2,0)) → TL=(2,0), BR=(2,0).
- Restart after the address for pixel 20 is issued, full image set → only one `done`, in cycle 51 after the second `start`; `pixel_count`=48, TL=(0,0), BR=(7,5).
- `reset` low mid-scan, then high → `busy`=0 and outputs 0 immediately (asynchronous); no `done`; the next `start` completes normally.
